// File: rtl/apb_slave_mon_pkg.sv
// Shared types and constants for the APB slave transaction monitor.
// Protocol checker codes are only consumed when APB_SLAVE_MON_PROTOCOL_CHECK_EN is defined.
package apb_slave_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } phase_e;

  localparam int PROT_W = 3;

  localparam logic [2:0] PERR_NONE           = 3'd0;
  localparam logic [2:0] PERR_ENABLE_IN_IDLE = 3'd1;
  localparam logic [2:0] PERR_NO_ENABLE      = 3'd2;
  localparam logic [2:0] PERR_CHANGED        = 3'd3;
  localparam logic [2:0] PERR_MULTI_SEL      = 3'd4;
  localparam logic [2:0] PERR_ABORT          = 3'd5;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/apb_slave_mon_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head; DEPTH must be a power of 2.
// The head reads as zero while empty so downstream outputs are clean after reset.
module apb_slave_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/apb_slave_txn_monitor.sv
// Passive APB slave-side monitor: rebuilds completed transfers and queues them for a proxy.
// Define APB_SLAVE_MON_PROTOCOL_CHECK_EN to compile in the protocol checker.
module apb_slave_txn_monitor
  import apb_slave_mon_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NO_OF_SLAVES = 1,
  parameter int DEPTH        = 8,
  parameter int WAIT_WIDTH   = 8,
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int SIDX_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
)(
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [NO_OF_SLAVES-1:0] psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic [STRB_W-1:0]       pstrb,
  input  logic [PROT_W-1:0]       pprot,
  output logic                    mon_valid,
  input  logic                    mon_ready,
  output logic [ADDR_WIDTH-1:0]   mon_addr,
  output logic                    mon_write,
  output logic [DATA_WIDTH-1:0]   mon_data,
  output logic [STRB_W-1:0]       mon_strb,
  output logic [PROT_W-1:0]       mon_prot,
  output logic                    mon_slverr,
  output logic [SIDX_W-1:0]       mon_slave_idx,
  output logic [WAIT_WIDTH-1:0]   mon_wait_cycles,
  output logic [CNT_W-1:0]        fifo_count,
  output logic [15:0]             overflow_count,
  output logic                    proto_err,
  output logic [2:0]              proto_err_code
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]     strb;
    logic [PROT_W-1:0]     prot;
    logic                  slverr;
    logic [SIDX_W-1:0]     slave_idx;
    logic [WAIT_WIDTH-1:0] wait_cycles;
  } mon_rec_t;

  localparam int REC_W = $bits(mon_rec_t);

  phase_e                phase_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  write_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_W-1:0]     strb_reg;
  logic [PROT_W-1:0]     prot_reg;
  logic [SIDX_W-1:0]     sidx_reg;
  logic [WAIT_WIDTH-1:0] wait_reg;
  logic [15:0]           overflow_reg;
  logic [SIDX_W-1:0]     sidx_next;
  logic                  sel_any;
  logic                  setup_seen;
  logic                  in_access;
  logic                  rec_push;
  logic                  rec_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  mon_rec_t              rec_in;
  mon_rec_t              rec_out;

  assign sel_any    = |psel;
  assign setup_seen = sel_any && !penable;
  // SETUP and ACCESS both mean the cycle now on the bus is an access cycle.
  assign in_access  = (phase_reg != IDLE);
  assign rec_push   = in_access && sel_any && penable && pready;

  always_comb begin
    sidx_next = '0;
    for (int i = NO_OF_SLAVES - 1; i >= 0; i--) begin
      if (psel[i]) begin
        sidx_next = SIDX_W'(i);
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      phase_reg <= IDLE;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      strb_reg  <= '0;
      prot_reg  <= '0;
      sidx_reg  <= '0;
      wait_reg  <= '0;
    end else begin
      case (phase_reg)
        IDLE: begin
          if (setup_seen) begin
            phase_reg <= SETUP;
            addr_reg  <= paddr;
            write_reg <= pwrite;
            wdata_reg <= pwdata;
            strb_reg  <= pstrb;
            prot_reg  <= pprot;
            sidx_reg  <= sidx_next;
            wait_reg  <= '0;
          end
        end
        SETUP, ACCESS: begin
          // Completion and abort both return to IDLE; IDLE re-arms on a fresh setup cycle.
          if (!sel_any || !penable || pready) begin
            phase_reg <= IDLE;
          end else begin
            phase_reg <= ACCESS;
            if (!(&wait_reg)) begin
              wait_reg <= wait_reg + 1'b1;
            end
          end
        end
        default: phase_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    rec_in             = '0;
    rec_in.addr        = addr_reg;
    rec_in.write       = write_reg;
    rec_in.data        = write_reg ? wdata_reg : prdata;
    rec_in.strb        = write_reg ? strb_reg : '0;
    rec_in.prot        = prot_reg;
    rec_in.slverr      = pslverr;
    rec_in.slave_idx   = sidx_reg;
    rec_in.wait_cycles = wait_reg;
  end

  apb_slave_mon_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (pclk),
    .rst   (preset),
    .push  (rec_push),
    .pop   (rec_pop),
    .din   (rec_in),
    .dout  (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign mon_valid       = !fifo_empty;
  assign rec_pop         = mon_valid && mon_ready;
  assign mon_addr        = rec_out.addr;
  assign mon_write       = rec_out.write;
  assign mon_data        = rec_out.data;
  assign mon_strb        = rec_out.strb;
  assign mon_prot        = rec_out.prot;
  assign mon_slverr      = rec_out.slverr;
  assign mon_slave_idx   = rec_out.slave_idx;
  assign mon_wait_cycles = rec_out.wait_cycles;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      overflow_reg <= '0;
    end else if (rec_push && fifo_full && !rec_pop) begin
      overflow_reg <= sat_inc16(overflow_reg);
    end
  end

  assign overflow_count = overflow_reg;

`ifdef APB_SLAVE_MON_PROTOCOL_CHECK_EN
  logic [NO_OF_SLAVES-1:0] sel_reg;
  logic                    proto_err_reg;
  logic [2:0]              proto_code_reg;
  logic [2:0]              viol_code;
  logic                    multi_sel;

  assign multi_sel = (psel & (psel - NO_OF_SLAVES'(1))) != '0;

  always_comb begin
    viol_code = PERR_NONE;
    if (phase_reg == IDLE) begin
      if (penable) begin
        viol_code = PERR_ENABLE_IN_IDLE;
      end
    end else if (phase_reg == SETUP && !penable) begin
      viol_code = PERR_NO_ENABLE;
    end else if (!sel_any || !penable) begin
      viol_code = PERR_ABORT;
    end else if (paddr != addr_reg || pwrite != write_reg || pwdata != wdata_reg ||
                 pstrb != strb_reg || pprot != prot_reg || psel != sel_reg) begin
      viol_code = PERR_CHANGED;
    end
    if (viol_code == PERR_NONE && multi_sel) begin
      viol_code = PERR_MULTI_SEL;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      sel_reg        <= '0;
      proto_err_reg  <= 1'b0;
      proto_code_reg <= PERR_NONE;
    end else begin
      if (phase_reg == IDLE && setup_seen) begin
        sel_reg <= psel;
      end
      proto_err_reg <= (viol_code != PERR_NONE);
      if (viol_code != PERR_NONE) begin
        proto_code_reg <= viol_code;
      end
    end
  end

  assign proto_err      = proto_err_reg;
  assign proto_err_code = proto_code_reg;
`else
  assign proto_err      = 1'b0;
  assign proto_err_code = 3'd0;
`endif

endmodule

// File: tb/tb_apb_slave_txn_monitor.sv
// Self-checking bench for apb_slave_txn_monitor (4 slaves, depth-4 FIFO).
// Expected records come from a queue model built from the transfer parameters the bench issues.
module tb_apb_slave_txn_monitor;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int DP = 4;
  localparam int WW = 8;

  logic          pclk = 1'b0;
  logic          preset;
  logic [NS-1:0] psel;
  logic          penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic          mon_valid, mon_ready;
  logic [AW-1:0] mon_addr;
  logic          mon_write;
  logic [DW-1:0] mon_data;
  logic [3:0]    mon_strb;
  logic [2:0]    mon_prot;
  logic          mon_slverr;
  logic [1:0]    mon_slave_idx;
  logic [WW-1:0] mon_wait_cycles;
  logic [2:0]    fifo_count;
  logic [15:0]   overflow_count;
  logic          proto_err;
  logic [2:0]    proto_err_code;

  apb_slave_txn_monitor #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NO_OF_SLAVES (NS),
    .DEPTH        (DP),
    .WAIT_WIDTH   (WW)
  ) dut (
    .pclk            (pclk),
    .preset          (preset),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .pready          (pready),
    .pslverr         (pslverr),
    .paddr           (paddr),
    .pwdata          (pwdata),
    .prdata          (prdata),
    .pstrb           (pstrb),
    .pprot           (pprot),
    .mon_valid       (mon_valid),
    .mon_ready       (mon_ready),
    .mon_addr        (mon_addr),
    .mon_write       (mon_write),
    .mon_data        (mon_data),
    .mon_strb        (mon_strb),
    .mon_prot        (mon_prot),
    .mon_slverr      (mon_slverr),
    .mon_slave_idx   (mon_slave_idx),
    .mon_wait_cycles (mon_wait_cycles),
    .fifo_count      (fifo_count),
    .overflow_count  (overflow_count),
    .proto_err       (proto_err),
    .proto_err_code  (proto_err_code)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic        slverr;
    logic [1:0]  idx;
    logic [7:0]  waits;
  } rec_t;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [3:0]  sel;
    int          waits;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_idx;
    logic [7:0]  exp_wait;
  } vec_t;

  rec_t model_q[$];
  int   model_ovf;
  int   n_checks;
  int   n_fail;
  bit   rand_ready;
  rec_t nul;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] lowest_sel(input logic [3:0] s);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  function automatic rec_t mk_rec(input logic [31:0] a, input logic w, input logic [31:0] wd,
                                  input logic [3:0] st, input logic [2:0] pr, input logic [3:0] sel,
                                  input int waits, input logic [31:0] rd, input logic err);
    rec_t r;
    r.addr   = a;
    r.write  = w;
    r.data   = w ? wd : rd;
    r.strb   = w ? st : 4'h0;
    r.prot   = pr;
    r.slverr = err;
    r.idx    = lowest_sel(sel);
    r.waits  = (waits > 255) ? 8'hFF : 8'(waits);
    return r;
  endfunction

  task automatic compare_state();
    check("mon_valid", 64'(mon_valid), 64'(model_q.size() > 0));
    check("fifo_count", 64'(fifo_count), 64'(model_q.size()));
    check("overflow_count", 64'(overflow_count), 64'(model_ovf));
    if (model_q.size() > 0) begin
      check("mon_addr", 64'(mon_addr), 64'(model_q[0].addr));
      check("mon_write", 64'(mon_write), 64'(model_q[0].write));
      check("mon_data", 64'(mon_data), 64'(model_q[0].data));
      check("mon_strb", 64'(mon_strb), 64'(model_q[0].strb));
      check("mon_prot", 64'(mon_prot), 64'(model_q[0].prot));
      check("mon_slverr", 64'(mon_slverr), 64'(model_q[0].slverr));
      check("mon_slave_idx", 64'(mon_slave_idx), 64'(model_q[0].idx));
      check("mon_wait_cycles", 64'(mon_wait_cycles), 64'(model_q[0].waits));
    end
`ifndef APB_SLAVE_MON_PROTOCOL_CHECK_EN
    check("proto_err_tied", 64'(proto_err), 64'(0));
    check("proto_code_tied", 64'(proto_err_code), 64'(0));
`endif
  endtask

  // One clock edge: model pop/push applied with the same rules the FIFO must obey.
  task automatic tick(input bit done, input rec_t r);
    bit pop;
    if (rand_ready) mon_ready = 1'($urandom_range(0, 1));
    pop = (model_q.size() > 0) && mon_ready;
    @(posedge pclk);
    if (pop) model_q.delete(0);
    if (done) begin
      if (model_q.size() < DP) model_q.push_back(r);
      else if (model_ovf < 65535) model_ovf++;
    end
    #1;
    compare_state();
  endtask

  task automatic bus_idle();
    psel    = '0;
    penable = 1'b0;
    pready  = 1'b0;
    tick(1'b0, nul);
  endtask

  task automatic apb_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr, input logic [3:0] sel,
                          input int waits, input logic [31:0] rd, input logic err,
                          input int done_ready = -1);
    rec_t r;
    r = mk_rec(a, w, wd, st, pr, sel, waits, rd, err);
    psel = sel; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd;
    pstrb = st; pprot = pr; pready = 1'b0; pslverr = 1'b0; prdata = ~rd;
    tick(1'b0, nul);
    penable = 1'b1;
    repeat (waits) tick(1'b0, nul);
    pready = 1'b1; prdata = rd; pslverr = err;
    if (done_ready >= 0) mon_ready = 1'(done_ready);
    tick(1'b1, r);
  endtask

  task automatic apb_abort(input logic [3:0] sel, input int waits);
    psel = sel; penable = 1'b0; paddr = $urandom; pwrite = 1'($urandom_range(0, 1));
    pready = 1'b0;
    tick(1'b0, nul);
    penable = 1'b1;
    repeat (waits) tick(1'b0, nul);
    psel = '0; penable = 1'b0;
    tick(1'b0, nul);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mon_valid"}, 64'(mon_valid), 64'(0));
    check({tag, "_fifo_count"}, 64'(fifo_count), 64'(0));
    check({tag, "_overflow"}, 64'(overflow_count), 64'(0));
    check({tag, "_mon_addr"}, 64'(mon_addr), 64'(0));
    check({tag, "_mon_write"}, 64'(mon_write), 64'(0));
    check({tag, "_mon_data"}, 64'(mon_data), 64'(0));
    check({tag, "_mon_strb"}, 64'(mon_strb), 64'(0));
    check({tag, "_mon_prot"}, 64'(mon_prot), 64'(0));
    check({tag, "_mon_slverr"}, 64'(mon_slverr), 64'(0));
    check({tag, "_mon_idx"}, 64'(mon_slave_idx), 64'(0));
    check({tag, "_mon_wait"}, 64'(mon_wait_cycles), 64'(0));
    check({tag, "_proto_err"}, 64'(proto_err), 64'(0));
    check({tag, "_proto_code"}, 64'(proto_err_code), 64'(0));
  endtask

  vec_t vecs[6];
  rec_t r5;
  int   kind;
  int   gap;

  initial begin
    vecs[0] = '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd0, 4'b0001, 0,   32'h0000_0000, 1'b0,
                32'hDEAD_BEEF, 4'hF, 2'd0, 8'd0};
    vecs[1] = '{32'h0000_0024, 1'b0, 32'h0BAD_0BAD, 4'hF, 3'd2, 4'b0001, 3,   32'h1234_5678, 1'b1,
                32'h1234_5678, 4'h0, 2'd0, 8'd3};
    vecs[2] = '{32'h0000_0100, 1'b1, 32'hA5A5_0001, 4'h3, 3'd5, 4'b0100, 1,   32'hFFFF_FFFF, 1'b0,
                32'hA5A5_0001, 4'h3, 2'd2, 8'd1};
    vecs[3] = '{32'h2000_0000, 1'b0, 32'h1111_1111, 4'hC, 3'd7, 4'b1000, 0,   32'hCAFE_F00D, 1'b0,
                32'hCAFE_F00D, 4'h0, 2'd3, 8'd0};
    vecs[4] = '{32'h0000_0044, 1'b1, 32'h0000_00FF, 4'h1, 3'd1, 4'b0110, 2,   32'h0000_0000, 1'b1,
                32'h0000_00FF, 4'h1, 2'd1, 8'd2};
    vecs[5] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 4'hF, 3'd0, 4'b0010, 300, 32'h5A5A_5A5A, 1'b0,
                32'h5A5A_5A5A, 4'h0, 2'd1, 8'hFF};

    n_checks = 0; n_fail = 0; model_ovf = 0; rand_ready = 1'b0;
    preset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; pready = 1'b0; pslverr = 1'b0;
    paddr = '0; pwdata = '0; prdata = '0; pstrb = '0; pprot = '0; mon_ready = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check_reset_outputs("reset");
    @(negedge pclk);
    preset = 1'b0;
    bus_idle();

    // Table vectors: each completes into an empty FIFO, so the record is at the head right after the edge.
    mon_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apb_xfer(vecs[i].addr, vecs[i].write, vecs[i].wdata, vecs[i].strb, vecs[i].prot,
               vecs[i].sel, vecs[i].waits, vecs[i].rdata, vecs[i].err);
      check("tbl_valid", 64'(mon_valid), 64'(1));
      check("tbl_addr", 64'(mon_addr), 64'(vecs[i].addr));
      check("tbl_write", 64'(mon_write), 64'(vecs[i].write));
      check("tbl_data", 64'(mon_data), 64'(vecs[i].exp_data));
      check("tbl_strb", 64'(mon_strb), 64'(vecs[i].exp_strb));
      check("tbl_slverr", 64'(mon_slverr), 64'(vecs[i].err));
      check("tbl_idx", 64'(mon_slave_idx), 64'(vecs[i].exp_idx));
      check("tbl_wait", 64'(mon_wait_cycles), 64'(vecs[i].exp_wait));
      $display("vector %0d addr=0x%0h data=0x%0h idx=%0d wait=%0d", i, mon_addr, mon_data,
               mon_slave_idx, mon_wait_cycles);
      bus_idle();
    end

    // Back-to-back transfers on slave 2 then slave 0 with no idle cycle.
    mon_ready = 1'b0;
    apb_xfer(32'h0000_0200, 1'b1, 32'h0000_0002, 4'hF, 3'd0, 4'b0100, 0, 32'h0, 1'b0);
    apb_xfer(32'h0000_0204, 1'b0, 32'h0, 4'hF, 3'd0, 4'b0001, 1, 32'h0000_0020, 1'b0);
    bus_idle();
    check("b2b_count", 64'(fifo_count), 64'(2));
    check("b2b_first_idx", 64'(mon_slave_idx), 64'(2));
    mon_ready = 1'b1;
    bus_idle();
    check("b2b_second_idx", 64'(mon_slave_idx), 64'(0));
    bus_idle();
    check("b2b_drained", 64'(mon_valid), 64'(0));
    $display("back-to-back transfers done");

    // Overflow: six transfers into a depth-4 FIFO with the proxy stalled.
    mon_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apb_xfer(32'h300 + 32'(i * 4), 1'b1, 32'h1000 + 32'(i), 4'hF, 3'd0, 4'b0001, 0, 32'h0, 1'b0);
      bus_idle();
    end
    check("ovf_count", 64'(fifo_count), 64'(4));
    check("ovf_dropped", 64'(overflow_count), 64'(2));
    mon_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 64'(mon_addr), 64'(32'h300 + 32'(i * 4)));
      bus_idle();
    end
    check("drain_empty", 64'(mon_valid), 64'(0));
    $display("overflow fill/drain done, overflow_count=%0d", overflow_count);

    // Full FIFO: push and pop on the same edge keeps occupancy and drops nothing.
    mon_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apb_xfer(32'h400 + 32'(i * 4), 1'b0, 32'h0, 4'h0, 3'd0, 4'b0001, 0, 32'h4000 + 32'(i), 1'b0);
      bus_idle();
    end
    apb_xfer(32'h0000_0410, 1'b0, 32'h0, 4'h0, 3'd0, 4'b0001, 0, 32'h0000_4004, 1'b0, 1);
    mon_ready = 1'b0;
    check("pushpop_count", 64'(fifo_count), 64'(4));
    check("pushpop_ovf", 64'(overflow_count), 64'(2));
    check("pushpop_head", 64'(mon_addr), 64'(32'h404));
    bus_idle();
    mon_ready = 1'b1;
    repeat (5) bus_idle();
    $display("full push+pop done");

    // Randomised traffic with aborts and random proxy back-pressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        apb_abort(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
      end else begin
        apb_xfer($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), 3'($urandom),
                 4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)));
      end
      gap = int'($urandom_range(0, 2));
      repeat (gap) bus_idle();
    end
    rand_ready = 1'b0;
    mon_ready = 1'b1;
    repeat (6) bus_idle();
    check("random_drained", 64'(mon_valid), 64'(0));
    $display("random traffic done, overflow_count=%0d", overflow_count);

`ifdef APB_SLAVE_MON_PROTOCOL_CHECK_EN
    // paddr moves during a wait state: one-cycle pulse with code 3, record keeps the latched address.
    bus_idle();
    psel = 4'b0001; penable = 1'b0; paddr = 32'h80; pwrite = 1'b1; pwdata = 32'h55AA;
    pstrb = 4'hF; pprot = 3'd0; pready = 1'b0; pslverr = 1'b0;
    tick(1'b0, nul);
    penable = 1'b1;
    tick(1'b0, nul);
    check("perr_quiet", 64'(proto_err), 64'(0));
    paddr = 32'h84;
    tick(1'b0, nul);
    check("perr_pulse", 64'(proto_err), 64'(1));
    check("perr_code", 64'(proto_err_code), 64'(3));
    paddr = 32'h80; pready = 1'b1;
    r5 = mk_rec(32'h80, 1'b1, 32'h55AA, 4'hF, 3'd0, 4'b0001, 2, 32'h0, 1'b0);
    tick(1'b1, r5);
    check("perr_cleared", 64'(proto_err), 64'(0));
    check("perr_code_held", 64'(proto_err_code), 64'(3));
    bus_idle();
    $display("protocol change check done");
`endif

    // Reset mid-ACCESS with records queued: everything returns to reset values.
    mon_ready = 1'b0;
    apb_xfer(32'h500, 1'b1, 32'h5, 4'hF, 3'd0, 4'b0001, 0, 32'h0, 1'b0);
    apb_xfer(32'h504, 1'b1, 32'h6, 4'hF, 3'd0, 4'b0010, 0, 32'h0, 1'b0);
    psel = 4'b0001; penable = 1'b0; paddr = 32'h508; pwrite = 1'b0; pready = 1'b0;
    tick(1'b0, nul);
    penable = 1'b1;
    tick(1'b0, nul);
    preset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    model_q.delete();
    model_ovf = 0;
    psel = '0; penable = 1'b0; pready = 1'b1; prdata = 32'h9999_9999;
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    bus_idle();
    bus_idle();
    check("postreset_valid", 64'(mon_valid), 64'(0));
    mon_ready = 1'b1;
    apb_xfer(32'h600, 1'b0, 32'h0, 4'h0, 3'd4, 4'b1000, 1, 32'h0000_0600, 1'b0);
    check("postreset_rec", 64'(mon_data), 64'(32'h600));
    bus_idle();
    $display("reset mid-access done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_txn_monitor.md
# apb_slave_txn_monitor

Passive, parametrised APB slave-side transaction monitor. It observes the APB bus on one or more slave selects, reconstructs each completed transfer with the APB phase state machine, and buffers completed records in a DEPTH-entry FIFO. The slave monitor proxy drains that FIFO through a valid/ready port. The block drives nothing onto the APB bus. It sits beside the slave agent BFMs in hdl_top.

## Interface
- ADDR_WIDTH, 32, paddr width
- DATA_WIDTH, 32, pwdata/prdata width; multiple of 8, range 8..1024
- NO_OF_SLAVES, 1, psel width, range 1..16
- DEPTH, 8, record FIFO depth; power of 2, minimum 2
- WAIT_WIDTH, 8, width of the saturating wait-cycle counter
- pclk  in  1  APB clock; all state updates on the rising edge
- preset  in  1  asynchronous, active-high reset
- psel  in  NO_OF_SLAVES  slave selects
- penable, pwrite, pready, pslverr  in  1  APB controls
- paddr  in  ADDR_WIDTH; pwdata, prdata  in  DATA_WIDTH; pstrb  in  DATA_WIDTH/8; pprot  in  3
- mon_valid  out  1  head record valid
- mon_ready  in  1  proxy accepts the head record
- mon_addr  out  ADDR_WIDTH; mon_write  out  1; mon_data  out  DATA_WIDTH; mon_strb  out  DATA_WIDTH/8; mon_prot  out  3; mon_slverr  out  1
- mon_slave_idx  out  SIDX_W  index of the selected slave; SIDX_W = max(1, clog2(NO_OF_SLAVES))
- mon_wait_cycles  out  WAIT_WIDTH  cycles spent with pready low
- fifo_count  out  clog2(DEPTH+1)  current occupancy
- overflow_count  out  16  records dropped because the FIFO was full; saturates at 16'hFFFF
- proto_err  out  1; proto_err_code  out  3  protocol checker outputs (see Configuration)

## Operation
- Phase FSM states:
  - IDLE:
    - |psel && !penable → SETUP.
    - Otherwise stay in IDLE.
  - SETUP:
    - Latch paddr, pwrite, pwdata, pstrb, pprot, the slave index and the psel value.
    - Clear the wait counter.
    - Always → ACCESS on the next edge.
  - ACCESS:
    - penable && pready:
      - Capture the record.
      - Next state is SETUP if |psel && !penable on the following cycle; otherwise IDLE.
      - Back-to-back transfers with no idle cycle are supported.
    - !pready: increment the wait counter, saturating at all-ones, and stay in ACCESS.
    - psel or penable dropped before pready: the transfer is aborted, no record is captured, next state is IDLE.
- Slave index is the position of the lowest set psel bit.
- Record data:
  - mon_data = pwdata latched in SETUP for writes.
  - mon_data = prdata sampled at the completion edge for reads.
  - mon_slverr is sampled at the completion edge.
  - mon_strb is all-zero for reads.
- FIFO rules:
  - Push when a record is captured.
  - Pop when mon_valid && mon_ready.
  - Push while full with a simultaneous pop: both happen, and occupancy is unchanged.
  - Push while full with no pop: the record is dropped, overflow_count increments, and FIFO contents are unchanged.
  - Pointers wrap modulo DEPTH.
- Reset mid-transfer: the FSM returns to IDLE, the partial record is discarded, the FIFO empties and all counters clear.

## Timing
- Reset values:
  - mon_valid = 0, fifo_count = 0, overflow_count = 0.
  - proto_err = 0, proto_err_code = 0.
  - All mon_* data outputs = 0.
- Latency: a record captured at completion edge N is visible on mon_* with mon_valid = 1 after edge N (registered) when the FIFO was empty.
- mon_* outputs are stable while mon_valid && !mon_ready.
- Throughput: one record per cycle in and one record per cycle out.

## Configuration
- APB_SLAVE_MON_PROTOCOL_CHECK_EN defined: checker compiled in. proto_err pulses for one cycle, registered one edge after the violating sample. proto_err_code holds the last error until reset. Codes:
  - 1: penable high in IDLE.
  - 2: penable low in the cycle after SETUP.
  - 3: paddr, pwrite, pwdata, pstrb, pprot or psel changed during ACCESS.
  - 4: more than one psel bit set.
  - 5: transfer aborted before pready.
- APB_SLAVE_MON_PROTOCOL_CHECK_EN undefined: checker logic absent. proto_err and proto_err_code are tied to 0; ports remain.
- FSM and record capture are identical in both builds.

## Structure
- Package apb_slave_mon_pkg holds:
  - phase enum (IDLE, SETUP, ACCESS);
  - proto_err code localparams;
  - parametrised record struct via typedef inside the module using package widths.
- Sub-module apb_slave_mon_fifo: generic synchronous FIFO with parameters WIDTH and DEPTH. It has push/pop/full/empty/count and an asynchronous active-high reset. It is instantiated once with the packed record.

## Test plan
- Zero-wait write: paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF, psel=1, pready high in ACCESS → one record: write=1, data=0xDEADBEEF, wait_cycles=0, mon_valid one edge after completion.
- Read with 3 wait states: prdata=0x12345678 at completion, pslverr=1 → record: write=0, data=0x12345678, strb=0, slverr=1, wait_cycles=3.
- NO_OF_SLAVES=4, back-to-back transfers on psel=4'b0100 then 4'b0001 with no idle cycle → two records, slave_idx 2 then 0.
- DEPTH=4 with mon_ready=0 and 6 transfers → fifo_count=4, overflow_count=2. Raising mon_ready drains the first four records in order.
- Full FIFO with push and pop on the same edge → fifo_count stays 4, overflow_count unchanged.
- With APB_SLAVE_MON_PROTOCOL_CHECK_EN: paddr changes during a wait state → proto_err pulses, code=3. Assert preset mid-ACCESS → no record, all outputs at reset values.
